// File: rtl/add8_share_arb.sv
// Round-robin share of one external 8-bit adder core among NREQ lanes: S1 operand register, S2 tagged response register.
// Optional error monitor (exact reference sum, rsp_err, saturating err_cnt) is built when ADD8_ERR_MON_EN is defined.
module add8_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        core_a,
  output logic [7:0]        core_b,
  input  logic [8:0]        core_o,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [8:0]        rsp_sum,
`ifdef ADD8_ERR_MON_EN
  output logic              rsp_err,
  output logic [15:0]       err_cnt,
`endif
  output logic              busy
);

  // Handshake: a beat moves when valid and ready are both high at a rising edge;
  // producers never look at ready to decide valid, ready may look at valid.
  logic            s1_valid;
  logic [7:0]      s1_a;
  logic [7:0]      s1_b;
  logic [IDW-1:0]  s1_id;
  logic [IDW-1:0]  ptr;

  logic            s2_free;
  logic            s1_free;
  logic [NREQ-1:0] grant;
  logic            gnt_any;
  logic [IDW-1:0]  gnt_idx;
  logic [7:0]      gnt_a;
  logic [7:0]      gnt_b;

  assign s2_free = !rsp_valid || rsp_ready;
  assign s1_free = !s1_valid || s2_free;

  // Scan offsets from ptr; the first valid lane in rotated order wins.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_a   = '0;
    gnt_b   = '0;
    if (s1_free) begin
      for (int k = 0; k < NREQ; k++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!gnt_any && req_valid[i] && (((int'(ptr) + k) % NREQ) == i)) begin
            gnt_any  = 1'b1;
            grant[i] = 1'b1;
            gnt_idx  = IDW'(i);
            gnt_a    = req_a[8*i +: 8];
            gnt_b    = req_b[8*i +: 8];
          end
        end
      end
    end
  end

  assign req_ready = grant & {NREQ{rst_n}};
  assign core_a    = s1_valid ? s1_a : 8'h00;
  assign core_b    = s1_valid ? s1_b : 8'h00;
  assign busy      = s1_valid || rsp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      ptr      <= '0;
    end else if (s1_free) begin
      s1_valid <= gnt_any;
      if (gnt_any) begin
        s1_a  <= gnt_a;
        s1_b  <= gnt_b;
        s1_id <= gnt_idx;
        ptr   <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
    end else if (s2_free) begin
      rsp_valid <= s1_valid;
      rsp_id    <= s1_id;
      rsp_sum   <= s1_valid ? core_o : 9'h000;
    end
  end

`ifdef ADD8_ERR_MON_EN
  logic [8:0] exact_sum;
  assign exact_sum = {1'b0, s1_a} + {1'b0, s1_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
    end else if (s2_free) begin
      rsp_err <= s1_valid && (core_o != exact_sum);
    end
  end

  // Counts consumed erroneous responses, sticking at full scale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (rsp_valid && rsp_ready && rsp_err && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_add8_share_arb.sv
// Bench for add8_share_arb: directed lane vectors, expected-response queue checked by a monitor.
// Define ADD8_ERR_MON_EN to exercise the error monitor with a core that flips bit 4.
module tb_add8_share_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef ADD8_ERR_MON_EN
  localparam logic [8:0] ERR_XOR = 9'h010;
`else
  localparam logic [8:0] ERR_XOR = 9'h000;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        core_a;
  logic [7:0]        core_b;
  logic [8:0]        core_o;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [8:0]        rsp_sum;
  logic              busy;
`ifdef ADD8_ERR_MON_EN
  logic              rsp_err;
  logic [15:0]       err_cnt;
`endif

  // Core model: exact adder, optionally with a deliberate bit-4 error.
  assign core_o = ({1'b0, core_a} + {1'b0, core_b}) ^ ERR_XOR;

  add8_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .core_a(core_a), .core_b(core_b), .core_o(core_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
`ifdef ADD8_ERR_MON_EN
    .rsp_err(rsp_err), .err_cnt(err_cnt),
`endif
    .busy(busy)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "bench timeout");
  end

  // Scoreboard state
  logic [IDW+8:0] exp_q[$];
  logic [IDW-1:0] gnt_log[$];
  logic [8:0]     lane_exp[NREQ];
  logic [IDW+8:0] exp_e;
  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int rsp_cnt = 0;
  int rsp_since_rst = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit before each rising edge.
  always @(negedge clk) begin
    #4;
    if (rst_n) begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_id), 32'hFFFF);
        end else begin
          exp_e = exp_q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(exp_e[IDW+8:9]));
          check("rsp_sum", 32'(rsp_sum), 32'(exp_e[8:0]));
`ifdef ADD8_ERR_MON_EN
          check("rsp_err", 32'(rsp_err), 32'd1);
`endif
        end
        rsp_cnt++;
        rsp_since_rst++;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back({IDW'(i), lane_exp[i] ^ ERR_XOR});
          gnt_log.push_back(IDW'(i));
          acc_cnt++;
        end
      end
    end
  end

  // Driver tasks
  task automatic set_lane(input int l, input logic [7:0] a, input logic [7:0] b, input logic [8:0] e);
    req_a[l*8 +: 8] = a;
    req_b[l*8 +: 8] = b;
    lane_exp[l]     = e;
  endtask

  task automatic send_one(input int l, input logic [7:0] a, input logic [7:0] b, input logic [8:0] e);
    logic ok;
    ok = 1'b0;
    set_lane(l, a, b, e);
    req_valid[l] = 1'b1;
    for (int c = 0; c < 20 && !ok; c++) begin
      #4;
      if (req_ready[l]) ok = 1'b1;
      @(negedge clk);
    end
    req_valid[l] = 1'b0;
    check("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 20 && busy; c++) @(negedge clk);
    @(negedge clk);
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_since_rst = 0;
  endtask

  int rr_exp[6] = '{0, 1, 2, 3, 0, 1};
  int acc0;
  int rsp0;

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) lane_exp[i] = '0;

    // Reset state with every lane requesting
    repeat (2) @(negedge clk);
    req_valid = '1;
    #2;
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_core_a", 32'(core_a), 32'd0);
`ifdef ADD8_ERR_MON_EN
    check("reset_err_cnt", 32'(err_cnt), 32'd0);
`endif
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single request on lane 2: 0x35 + 0x4A = 0x07F
    @(negedge clk);
    set_lane(2, 8'h35, 8'h4A, 9'h07F);
    req_valid[2] = 1'b1;
    #4;
    check("single_grant", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid[2] = 1'b0;
    check("single_lat1_valid", 32'(rsp_valid), 32'd0);
    check("single_lat1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("single_valid", 32'(rsp_valid), 32'd1);
    check("single_id", 32'(rsp_id), 32'd2);
    check("single_sum", 32'(rsp_sum), 32'(9'h07F ^ ERR_XOR));
    @(negedge clk);
    check("single_busy_off", 32'(busy), 32'd0);

    // Directed vectors including carry-out
    send_one(1, 8'hFF, 8'hFF, 9'h1FE);
    send_one(0, 8'h80, 8'h80, 9'h100);
    send_one(3, 8'h00, 8'h00, 9'h000);
    send_one(2, 8'h12, 8'h34, 9'h046);
    wait_drain();

    // Round-robin with all lanes valid
    do_reset();
    gnt_log.delete();
    set_lane(0, 8'h01, 8'h02, 9'h003);
    set_lane(1, 8'h10, 8'h20, 9'h030);
    set_lane(2, 8'h7F, 8'h01, 9'h080);
    set_lane(3, 8'hC0, 8'h50, 9'h110);
    req_valid = '1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 6) req_valid = '0;
      if (k >= 2 && k <= 7) check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    check("rr_tail_valid", 32'(rsp_valid), 32'd0);
    check("rr_grant_count", 32'(gnt_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) check("rr_grant_order", 32'(gnt_log[i]), 32'(rr_exp[i]));
    wait_drain();

    // Backpressure: consumer stalled for 5 cycles
    do_reset();
    acc0 = acc_cnt;
    rsp0 = rsp_cnt;
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        check("bp_req_ready", 32'(req_ready), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp_rsp_id", 32'(rsp_id), 32'd0);
        check("bp_rsp_sum", 32'(rsp_sum), 32'(9'h003 ^ ERR_XOR));
      end
    end
    check("bp_accepts", 32'(acc_cnt - acc0), 32'd2);
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_drain();
    check("bp_responses", 32'(rsp_cnt - rsp0), 32'd2);

    // Reset while FULL, then lanes 3 and 1 compete
    do_reset();
    rsp_ready = 1'b0;
    req_valid = '1;
    repeat (3) @(negedge clk);
    check("full_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_req_ready", 32'(req_ready), 32'd0);
    exp_q.delete();
    @(negedge clk);
    req_valid = 4'b1010;
    gnt_log.delete();
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    rsp_since_rst = 0;
    repeat (2) @(negedge clk);
    req_valid = '0;
    check("post_rst_grants", 32'(gnt_log.size()), 32'd2);
    check("post_rst_first", 32'(gnt_log[0]), 32'd1);
    check("post_rst_second", 32'(gnt_log[1]), 32'd3);
    wait_drain();

`ifdef ADD8_ERR_MON_EN
    // Error counter tracks responses, then saturates from a preload
    check("err_cnt_match", 32'(err_cnt), 32'(rsp_since_rst));
    @(negedge clk);
    force dut.err_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.err_cnt;
    send_one(0, 8'h11, 8'h22, 9'h033);
    send_one(1, 8'h44, 8'h55, 9'h099);
    send_one(2, 8'hF0, 8'h20, 9'h110);
    wait_drain();
    check("err_cnt_sat", 32'(err_cnt), 32'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
